regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 112 +++++++++++
 tb/tb_regfile_sb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard, two combinational read ports, and write-through bypass.
// Latency: reads are zero-cycle; writes, busy updates, busy_cnt and sb_err take effect at the next rising edge.
// Backpressure: none; the block never stalls and reports hazards through rd_busy1/rd_busy2.
module regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              sb_err
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;
    logic              sb_err_q;
    logic              sb_err_d;

    // Effective strobes: index 0 is inert when hardwired to zero.
    logic wr_act;
    logic iss_act;
    logic wr_byp;

    // Qualify strobes; the bypass is disabled while reset is held so reads show stored state.
    always_comb begin
        wr_act  = wr_en  && !((ZERO_R0 != 0) && (wr_addr  == '0));
        iss_act = iss_en && !((ZERO_R0 != 0) && (iss_addr == '0));
        wr_byp  = wr_act && rst_n;
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = regs_q[a];
        if (wr_byp && (wr_addr == a)) v = wr_data;
        if ((ZERO_R0 != 0) && (a == '0)) v = '0;
        return v;
    endfunction

    // A same-cycle write resolves the hazard unless the same index is being re-issued.
    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        logic b;
        b = busy_q[a];
        if (wr_byp && (wr_addr == a) && !(iss_act && (iss_addr == a))) b = 1'b0;
        if ((ZERO_R0 != 0) && (a == '0)) b = 1'b0;
        return b;
    endfunction

    // Read ports: combinational from current state plus the in-flight write.
    always_comb begin
        rd_data1 = read_data(rd_addr1);
        rd_data2 = read_data(rd_addr2);
        rd_busy1 = read_busy(rd_addr1);
        rd_busy2 = read_busy(rd_addr2);
    end

    // Next state: write data, clear-then-set busy so a same-index issue wins, recount, sticky error.
    always_comb begin
        regs_d = regs_q;
        if (wr_act) regs_d[wr_addr] = wr_data;

        busy_d = busy_q;
        if (wr_act)  busy_d[wr_addr]  = 1'b0;
        if (iss_act) busy_d[iss_addr] = 1'b1;

        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end

        sb_err_d = sb_err_q | (wr_act & ~busy_q[wr_addr]);
    end

    // State registers; synchronous reset overrides every simultaneous write or issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
    assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against a reference model.
// Latency: read outputs checked before each edge, registered state checked on the following falling edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, iss_addr;
    logic [DW-1:0] rd_data1, rd_data2, wr_data;
    logic          rd_busy1, rd_busy2, wr_en, iss_en, sb_err;
    logic [AW:0]   busy_cnt;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_cnt(busy_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents, pending set, pending count, sticky error.
    logic [DW-1:0] m_reg  [NR];
    bit            m_busy [NR];
    int            m_cnt;
    bit            m_err;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    // Architectural rules applied to one clock edge.
    task automatic model_edge();
        bit do_wr, do_iss;
        if (!rst_n) begin
            model_reset();
            return;
        end
        do_wr  = wr_en  && (wr_addr  != 0);
        do_iss = iss_en && (iss_addr != 0);
        if (do_wr) begin
            if (!m_busy[wr_addr]) m_err = 1'b1;
            m_reg[wr_addr] = wr_data;
        end
        if (do_wr && do_iss && (wr_addr == iss_addr)) begin
            if (!m_busy[iss_addr]) begin m_busy[iss_addr] = 1'b1; m_cnt++; end
        end else begin
            if (do_wr && m_busy[wr_addr])    begin m_busy[wr_addr]  = 1'b0; m_cnt--; end
            if (do_iss && !m_busy[iss_addr]) begin m_busy[iss_addr] = 1'b1; m_cnt++; end
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (rst_n && wr_en && (wr_addr == a)) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (rst_n && wr_en && (wr_addr == a) && !(iss_en && (iss_addr == a))) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic drive(input logic rst, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic ie, input logic [AW-1:0] ia,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        rst_n = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; rd_addr1 = r1; rd_addr2 = r2;
    endtask

    // One cycle: check reads before the edge, advance model at the edge, check state after it.
    task automatic step();
        #2;
        chk("rd_data1", rd_data1, exp_data(rd_addr1));
        chk("rd_data2", rd_data2, exp_data(rd_addr2));
        chk("rd_busy1", {31'd0, rd_busy1}, {31'd0, exp_busy(rd_addr1)});
        chk("rd_busy2", {31'd0, rd_busy2}, {31'd0, exp_busy(rd_addr2)});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("busy_cnt", {26'd0, busy_cnt}, m_cnt);
        chk("sb_err", {31'd0, sb_err}, {31'd0, m_err});
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset state; bypass must not leak through while reset is held.
        drive(0, 1, 9, 32'hFFFF_FFFF, 1, 9, 9, 4);
        #2;
        chk("rst_rd1", rd_data1, 32'h0);
        chk("rst_cnt", {26'd0, busy_cnt}, 32'd0);
        chk("rst_err", {31'd0, sb_err}, 32'd0);
        step();

        // Basic write/read.
        drive(1, 1, 10, 15, 0, 0, 0, 0);  step();
        drive(1, 1, 11, 10, 0, 0, 0, 0);  step();
        drive(1, 0, 0, 0, 0, 0, 10, 11);
        #2;
        chk("r10", rd_data1, 32'd15);
        chk("r11", rd_data2, 32'd10);
        chk("r10_busy", {31'd0, rd_busy1}, 32'd0);
        step();

        // Bypass: old value first, then write-through in the same cycle.
        do_reset();
        drive(1, 1, 5, 32'h11, 0, 0, 0, 0);  step();
        drive(1, 0, 0, 0, 0, 0, 5, 5);
        #2; chk("byp_old", rd_data1, 32'h11);
        step();
        drive(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 5, 6);
        #2; chk("byp_new", rd_data1, 32'hDEAD_BEEF);
        step();

        // Zero register.
        do_reset();
        drive(1, 1, 0, 32'h1234, 1, 0, 0, 0);
        #2;
        chk("r0_byp", rd_data1, 32'h0);
        chk("r0_busy", {31'd0, rd_busy1}, 32'd0);
        step();
        chk("r0_cnt", {26'd0, busy_cnt}, 32'd0);
        chk("r0_err", {31'd0, sb_err}, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #2; chk("r0_read", rd_data1, 32'h0);
        step();

        // Scoreboard sequence on R3.
        drive(1, 0, 0, 0, 1, 3, 3, 3);  step();
        chk("sb_cnt1", {26'd0, busy_cnt}, 32'd1);
        drive(1, 0, 0, 0, 1, 3, 3, 3);
        #2; chk("sb_busy3", {31'd0, rd_busy1}, 32'd1);
        step();
        chk("sb_cnt_dup", {26'd0, busy_cnt}, 32'd1);
        drive(1, 1, 3, 32'hA5A5, 1, 3, 3, 3);  step();
        chk("sb_setwin", {26'd0, busy_cnt}, 32'd1);
        drive(1, 0, 0, 0, 0, 0, 3, 3);
        #2;
        chk("sb_data3", rd_data1, 32'hA5A5);
        chk("sb_busy_hold", {31'd0, rd_busy2}, 32'd1);
        step();
        drive(1, 1, 3, 32'h77, 0, 0, 3, 0);  step();
        chk("sb_cnt0", {26'd0, busy_cnt}, 32'd0);
        chk("sb_no_err", {31'd0, sb_err}, 32'd0);

        // Sticky error on write to a non-pending register.
        do_reset();
        drive(1, 1, 7, 32'h7, 0, 0, 7, 0);  step();
        chk("err_set", {31'd0, sb_err}, 32'd1);
        drive(1, 0, 0, 0, 0, 0, 7, 0);  step();
        chk("err_hold", {31'd0, sb_err}, 32'd1);
        do_reset();
        chk("err_clr", {31'd0, sb_err}, 32'd0);

        // Reset mid-operation discards pending state.
        for (int r = 1; r <= 4; r++) begin
            drive(1, 0, 0, 0, 1, AW'(r), 0, 0);  step();
        end
        drive(1, 1, 2, 32'h55, 1, 2, 2, 0);  step();
        chk("mid_cnt4", {26'd0, busy_cnt}, 32'd4);
        drive(0, 1, 2, 32'hAA, 1, 5, 2, 3);  step();
        drive(1, 0, 0, 0, 0, 0, 2, 3);
        #2;
        chk("mid_r2", rd_data1, 32'h0);
        chk("mid_busy2", {31'd0, rd_busy1}, 32'd0);
        chk("mid_busy3", {31'd0, rd_busy2}, 32'd0);
        chk("mid_cnt", {26'd0, busy_cnt}, 32'd0);
        step();

        // Randomized traffic, concentrated on a few registers to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] wa, ia, r1, r2;
            logic          rst, we, ie;
            wa  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            ia  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            r1  = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
            r2  = ($urandom_range(0, 3) == 0) ? r1 : (($urandom_range(0, 2) == 0) ? ia : AW'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 49) != 0);
            we  = ($urandom_range(0, 1) == 1);
            ie  = ($urandom_range(0, 1) == 1);
            drive(rst, we, wa, DW'($urandom), ie, ia, r1, r2);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
